pool_window_gather: RTL and testbench

- Sits directly upstream of the 2x2 average-pooling stage in Layer3.
- Accepts a raster-scan stream of feature-map pixels, one pixel (all FM_DEPTH channels) per valid cycle.
- Buffers one even row, pairs it with the following odd row, and emits one complete 2x2 window per channel with a single-cycle valid strobe.
- The pooling stage's data-valid and 4-element input connect directly to this block's outputs.

---
 rtl/pool_pkg.sv | 20 ++
 rtl/pool_line_buffer.sv | 32 +++
 rtl/pool_window_gather.sv | 122 ++++++++++++
 tb/tb_pool_window_gather.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared types and constants for the Layer3 2x2 pooling path (window gather + pooling stage).
package pool_pkg;

  localparam int unsigned PIX_W = 16;
  localparam int unsigned WIN_N = 4;

  typedef logic signed [PIX_W-1:0] pix_t;

  // Element positions inside one 2x2 window
  localparam int unsigned WIN_TL = 0;
  localparam int unsigned WIN_TR = 1;
  localparam int unsigned WIN_BL = 2;
  localparam int unsigned WIN_BR = 3;

  typedef enum logic [0:0] {
    ROW_TOP = 1'b0,
    ROW_BOT = 1'b1
  } row_state_e;

endpackage

// File: rtl/pool_line_buffer.sv
// One-row pixel store: single write port, combinational reads of columns col-1 and col.
module pool_line_buffer
  import pool_pkg::*;
#(
  parameter int unsigned FM_WIDTH = 16,
  parameter int unsigned FM_DEPTH = 64,
  parameter int unsigned COL_W    = 4
) (
  input  logic                             clk,
  input  logic                             wr_en,
  input  logic [COL_W-1:0]                 wr_col,
  input  logic [FM_DEPTH-1:0][PIX_W-1:0]   wr_pix,
  input  logic [COL_W-1:0]                 rd_col,
  output logic [FM_DEPTH-1:0][PIX_W-1:0]   rd_left_c,
  output logic [FM_DEPTH-1:0][PIX_W-1:0]   rd_right_c
);

  logic [FM_DEPTH-1:0][PIX_W-1:0] mem [FM_WIDTH];
  logic [COL_W-1:0]               rd_col_prev;

  // Contents are overwritten every even row, so no reset is needed
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_col] <= wr_pix;
    end
  end

  assign rd_col_prev = rd_col - COL_W'(1);
  assign rd_left_c   = mem[rd_col_prev];
  assign rd_right_c  = mem[rd_col];

endmodule

// File: rtl/pool_window_gather.sv
// Gathers raster-scan pixels into 2x2 windows per channel for the pooling stage.
// Optional macro POOL_WIN_SOF_EN adds a start-of-frame input that realigns the counters.
module pool_window_gather
  import pool_pkg::*;
#(
  parameter int unsigned FM_DEPTH  = 64,
  parameter int unsigned FM_WIDTH  = 16,
  parameter int unsigned FM_HEIGHT = 16
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic                                   pix_valid,
`ifdef POOL_WIN_SOF_EN
  input  logic                                   sof,
`endif
  input  logic [FM_DEPTH-1:0][PIX_W-1:0]         pix_in,
  output logic                                   win_valid,
  output logic [FM_DEPTH-1:0][WIN_N-1:0][PIX_W-1:0] win_out,
  output logic                                   frame_done
);

  localparam int unsigned COL_W = (FM_WIDTH  > 2) ? $clog2(FM_WIDTH)  : 1;
  localparam int unsigned ROW_W = (FM_HEIGHT > 2) ? $clog2(FM_HEIGHT) : 1;

  if ((FM_WIDTH % 2) != 0 || FM_WIDTH == 0) begin : g_bad_width
    $error("pool_window_gather: FM_WIDTH must be even and non-zero");
  end
  if ((FM_HEIGHT % 2) != 0 || FM_HEIGHT == 0) begin : g_bad_height
    $error("pool_window_gather: FM_HEIGHT must be even and non-zero");
  end

  row_state_e                     state;
  logic [COL_W-1:0]               col;
  logic [ROW_W-1:0]               row;
  logic [FM_DEPTH-1:0][PIX_W-1:0] left;

  logic                           sof_c;
  logic                           col_last_c;
  logic                           row_last_c;
  logic                           lb_wr_en_c;
  logic [COL_W-1:0]               lb_wr_col_c;
  logic [FM_DEPTH-1:0][PIX_W-1:0] lb_left_c;
  logic [FM_DEPTH-1:0][PIX_W-1:0] lb_right_c;

`ifdef POOL_WIN_SOF_EN
  assign sof_c = sof;
`else
  assign sof_c = 1'b0;
`endif

  assign col_last_c  = (col == COL_W'(FM_WIDTH - 1));
  assign row_last_c  = (row == ROW_W'(FM_HEIGHT - 1));
  // A start-of-frame pixel always lands in column 0 of a fresh top row
  assign lb_wr_en_c  = pix_valid && (sof_c || (state == ROW_TOP));
  assign lb_wr_col_c = sof_c ? '0 : col;

  pool_line_buffer #(
    .FM_WIDTH (FM_WIDTH),
    .FM_DEPTH (FM_DEPTH),
    .COL_W    (COL_W)
  ) u_line_buf (
    .clk        (clk),
    .wr_en      (lb_wr_en_c),
    .wr_col     (lb_wr_col_c),
    .wr_pix     (pix_in),
    .rd_col     (col),
    .rd_left_c  (lb_left_c),
    .rd_right_c (lb_right_c)
  );

  // Raster counters, row-pair FSM and registered window outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ROW_TOP;
      col        <= '0;
      row        <= '0;
      left       <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      win_out    <= '0;
    end else begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (pix_valid) begin
        if (sof_c) begin
          col   <= COL_W'(1);
          row   <= '0;
          state <= ROW_TOP;
        end else begin
          if (col_last_c) begin
            col <= '0;
            row <= row_last_c ? '0 : row + ROW_W'(1);
          end else begin
            col <= col + COL_W'(1);
          end
          case (state)
            ROW_TOP: begin
              if (col_last_c) state <= ROW_BOT;
            end
            ROW_BOT: begin
              if (!col[0]) begin
                left <= pix_in;
              end else begin
                win_valid  <= 1'b1;
                frame_done <= row_last_c && col_last_c;
                for (int c = 0; c < int'(FM_DEPTH); c++) begin
                  win_out[c][WIN_TL] <= lb_left_c[c];
                  win_out[c][WIN_TR] <= lb_right_c[c];
                  win_out[c][WIN_BL] <= left[c];
                  win_out[c][WIN_BR] <= pix_in[c];
                end
              end
              if (col_last_c) state <= ROW_TOP;
            end
            default: state <= ROW_TOP;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_pool_window_gather.sv
// Scoreboard bench for pool_window_gather (FM_DEPTH=2, FM_WIDTH=4, FM_HEIGHT=4).
module tb_pool_window_gather;

  localparam int D = 2;
  localparam int W = 4;
  localparam int H = 4;

  typedef struct {
    logic [D-1:0][3:0][15:0] win;
    logic                    fd;
    int                      cyc;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    rstn;
  logic                    pix_valid;
  logic                    sof;
  logic [D-1:0][15:0]      pix_in;
  logic                    win_valid;
  logic [D-1:0][3:0][15:0] win_out;
  logic                    frame_done;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   fd_cnt = 0;
  bit   neg_mode = 1'b0;
  exp_t exp_q[$];

  pool_window_gather #(
    .FM_DEPTH  (D),
    .FM_WIDTH  (W),
    .FM_HEIGHT (H)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .pix_valid  (pix_valid),
`ifdef POOL_WIN_SOF_EN
    .sof        (sof),
`endif
    .pix_in     (pix_in),
    .win_valid  (win_valid),
    .win_out    (win_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] pv(input int r, input int c, input int ch);
    if (neg_mode && ch == 0) return 16'(-32768 + c);
    return 16'(100 * r + 10 * c + ch);
  endfunction

  // Scoreboard monitor: every strobe must match the oldest expected window
  always @(negedge clk) begin
    if (rstn) begin
      if (win_valid) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_strobe: got win_valid=1 want no strobe, win_out=%h", win_out);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          total++;
          if (win_out !== e.win) begin
            bad++;
            $display("FAIL win_data: got %h want %h", win_out, e.win);
          end
          total++;
          if (frame_done !== e.fd) begin
            bad++;
            $display("FAIL frame_done: got %0b want %0b", frame_done, e.fd);
          end
          total++;
          if (cyc != e.cyc + 1) begin
            bad++;
            $display("FAIL latency: got %0d cycles want 1", cyc - e.cyc);
          end
        end
        if (frame_done) fd_cnt++;
      end else if (frame_done) begin
        total++; bad++;
        $display("FAIL orphan_frame_done: got frame_done=1 with win_valid=0 want 0");
      end
    end
  end

  // Drive one pixel for one cycle; push the expected window when it is a bottom-right pixel
  task automatic send_pix(input int r, input int c, input int gap, input bit s);
    exp_t e;
    pix_valid = 1'b1;
    sof       = s;
    for (int ch = 0; ch < D; ch++) pix_in[ch] = pv(r, c, ch);
    if ((r % 2 == 1) && (c % 2 == 1)) begin
      for (int ch = 0; ch < D; ch++) begin
        e.win[ch][0] = pv(r - 1, c - 1, ch);
        e.win[ch][1] = pv(r - 1, c, ch);
        e.win[ch][2] = pv(r, c - 1, ch);
        e.win[ch][3] = pv(r, c, ch);
      end
      e.fd  = (r == H - 1) && (c == W - 1);
      e.cyc = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    sof = 1'b0;
    if (gap > 0) begin
      pix_valid = 1'b0;
      pix_in    = '1;
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic send_frame(input int gap, input bit s);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        send_pix(r, c, gap, s && r == 0 && c == 0);
  endtask

  task automatic idle();
    pix_valid = 1'b0;
    sof       = 1'b0;
  endtask

  // Bounded wait for all expected windows to be observed
  task automatic drain(input string name);
    idle();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin @(posedge clk); #1; end
    repeat (3) begin @(posedge clk); #1; end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_missing_strobes: got %0d pending want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset(input string name);
    @(negedge clk);
    total++;
    if (win_valid !== 1'b0) begin bad++; $display("FAIL %s_win_valid: got %0b want 0", name, win_valid); end
    total++;
    if (frame_done !== 1'b0) begin bad++; $display("FAIL %s_frame_done: got %0b want 0", name, frame_done); end
    total++;
    if (win_out !== '0) begin bad++; $display("FAIL %s_win_out: got %h want 0", name, win_out); end
  endtask

  initial begin
    rstn      = 1'b0;
    pix_valid = 1'b0;
    sof       = 1'b0;
    pix_in    = '0;
    repeat (3) @(posedge clk);
    check_reset("reset");
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    // Continuous frame
    send_frame(0, 1'b0);
    drain("continuous");

    // Three idle cycles after every pixel
    send_frame(3, 1'b0);
    drain("gapped");

    // Two back-to-back frames
    fd_cnt = 0;
    send_frame(0, 1'b0);
    send_frame(0, 1'b0);
    drain("back_to_back");
    total++;
    if (fd_cnt != 2) begin bad++; $display("FAIL frame_done_count: got %0d want 2", fd_cnt); end

    // Reset after pixel (1,0), then a full frame
    for (int c = 0; c < W; c++) send_pix(0, c, 0, 1'b0);
    send_pix(1, 0, 0, 1'b0);
    idle();
    rstn = 1'b0;
    check_reset("mid_reset");
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    send_frame(0, 1'b0);
    drain("after_reset");

    // Negative channel-0 values pass through bit-exact
    neg_mode = 1'b1;
    send_frame(1, 1'b0);
    drain("negative");
    neg_mode = 1'b0;

`ifdef POOL_WIN_SOF_EN
    // Partial frame aborted by start-of-frame
    for (int c = 0; c < W; c++) send_pix(0, c, 0, 1'b0);
    send_pix(1, 0, 0, 1'b0);
    send_frame(0, 1'b1);
    drain("sof");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
